// File: rtl/echo_width_meter.sv
// echo_width_meter: multi-channel ultrasonic echo pulse-width meter.
// Each channel synchronises its echo pin, counts the high time in prescaled
// ticks, saturates at TIMEOUT_TICKS and reports with one-cycle strobes.
module echo_width_meter #(
    parameter int unsigned N_CH          = 3,
    parameter int unsigned WIDTH         = 16,
    parameter int unsigned PRESCALE      = 50,
    parameter int unsigned TIMEOUT_TICKS = 30000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       echo,
    output logic [N_CH-1:0]       busy,
    output logic [N_CH-1:0]       done,
    output logic [N_CH-1:0]       timeout,
    output logic [N_CH*WIDTH-1:0] period
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        WAIT_LOW
    } state_t;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        logic             sync1_q;
        logic             sync2_q;   // echo_s
        logic             echo_d_q;
        logic             rise;
        logic             fall;
        state_t           state_q;
        logic [PW-1:0]    pre_q;
        logic [PW-1:0]    pre_base;
        logic [PW-1:0]    pre_d;
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_base;
        logic [WIDTH-1:0] cnt_d;
        logic             tick;
        logic             sat;
        logic [WIDTH-1:0] period_q;
        logic             done_q;
        logic             timeout_q;
        logic             busy_q;

        // Edge detect on the synchronised echo and next prescaler/count values.
        // The rise cycle itself is a high cycle, so counting starts from a
        // cleared base in IDLE and that cycle is accumulated immediately.
        always_comb begin
            rise     = sync2_q & ~echo_d_q;
            fall     = ~sync2_q & echo_d_q;
            pre_base = (state_q == IDLE) ? '0 : pre_q;
            cnt_base = (state_q == IDLE) ? '0 : cnt_q;
            tick     = (32'(pre_base) == PRESCALE - 1);
            pre_d    = tick ? '0 : pre_base + 1'b1;
            cnt_d    = tick ? cnt_base + 1'b1 : cnt_base;
            sat      = tick && (32'(cnt_base) == TIMEOUT_TICKS - 1);
        end

        // Synchroniser, measurement FSM and registered result outputs.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                echo_d_q  <= 1'b1;
                state_q   <= WAIT_LOW;
                pre_q     <= '0;
                cnt_q     <= '0;
                period_q  <= '0;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                busy_q    <= 1'b0;
            end else begin
                sync1_q   <= echo[i];
                sync2_q   <= sync1_q;
                echo_d_q  <= sync2_q;
                done_q    <= 1'b0;
                timeout_q <= 1'b0;
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            pre_q <= pre_d;
                            cnt_q <= cnt_d;
                            if (sat) begin
                                period_q  <= WIDTH'(TIMEOUT_TICKS);
                                done_q    <= 1'b1;
                                timeout_q <= 1'b1;
                                state_q   <= WAIT_LOW;
                            end else begin
                                state_q <= COUNT;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                    COUNT: begin
                        if (fall) begin
                            period_q <= cnt_q;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                            busy_q   <= 1'b0;
                        end else if (sync2_q) begin
                            pre_q <= pre_d;
                            cnt_q <= cnt_d;
                            if (sat) begin
                                period_q  <= WIDTH'(TIMEOUT_TICKS);
                                done_q    <= 1'b1;
                                timeout_q <= 1'b1;
                                state_q   <= WAIT_LOW;
                                busy_q    <= 1'b0;
                            end
                        end
                    end
                    WAIT_LOW: begin
                        if (!sync2_q) begin
                            state_q <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= WAIT_LOW;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end

        assign period[i*WIDTH +: WIDTH] = period_q;
        assign done[i]                  = done_q;
        assign timeout[i]               = timeout_q;
        assign busy[i]                  = busy_q;
    end

endmodule

// File: tb/tb_echo_width_meter.sv
// Scoreboard bench for echo_width_meter (3 channels, PRESCALE=4, TIMEOUT=100).
module tb_echo_width_meter;

    localparam int unsigned N_CH   = 3;
    localparam int unsigned W      = 16;
    localparam int          T_PRE  = 4;
    localparam int          T_TO   = 100;

    logic              clk;
    logic              rst;
    logic [N_CH-1:0]   echo;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   done;
    logic [N_CH-1:0]   timeout;
    logic [N_CH*W-1:0] period;

    typedef struct {
        int ch;
        int per;
        int to;
        int when;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_vec    = 0;
    int   n_err    = 0;

    echo_width_meter #(
        .N_CH         (N_CH),
        .WIDTH        (W),
        .PRESCALE     (T_PRE),
        .TIMEOUT_TICKS(T_TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .echo   (echo),
        .busy   (busy),
        .done   (done),
        .timeout(timeout),
        .period (period)
    );

    // Free-running clock and posedge counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Drive one high pulse of w clk on a channel and predict its result.
    task automatic pulse(input int ch, input int w);
        int   a;
        exp_t e;
        @(negedge clk);
        echo[ch] = 1'b1;
        a        = cyc;
        e.ch     = ch;
        if (w / T_PRE >= T_TO) begin
            e.per  = T_TO;
            e.to   = 1;
            e.when = a + T_TO * T_PRE + 2;
        end else begin
            e.per  = w / T_PRE;
            e.to   = 0;
            e.when = a + w + 3;
        end
        sb.push_back(e);
        for (int k = 0; k < w; k++) begin
            @(negedge clk);
            if (k == 9 && w >= 12) check("busy_in_count", 32'(busy[ch]), 1);
        end
        echo[ch] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("sb_drain", sb.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Output monitor: every done must match the oldest pending entry for its channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int c = 0; c < int'(N_CH); c++) begin
                if (timeout[c] && !done[c]) check("timeout_without_done", 1, 0);
                if (done[c]) begin
                    int idx;
                    idx = -1;
                    for (int j = 0; j < sb.size(); j++) begin
                        if (idx < 0 && sb[j].ch == c) idx = j;
                    end
                    if (idx < 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        check("period", 32'(period[c*W +: W]), sb[idx].per);
                        check("timeout", 32'(timeout[c]), sb[idx].to);
                        check("done_cycle", cyc, sb[idx].when);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst  = 1'b1;
        echo = '0;
        repeat (3) @(negedge clk);
        check("rst_period", period, 0);
        check("rst_done", 32'(done), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // 1: single pulse on ch0
        pulse(0, 40);
        drain();

        // 2: back-to-back pulses on ch1 (one low cycle between)
        pulse(1, 43);
        pulse(1, 3);
        drain();

        // 3: saturation on ch2, then a fresh measurement
        pulse(2, 1000);
        drain();
        pulse(2, 8);
        drain();

        // 4: simultaneous rises, different widths
        fork
            pulse(0, 8);
            pulse(1, 16);
            pulse(2, 24);
        join
        drain();

        // 6: explicit fall-to-done latency plus PRESCALE boundaries
        pulse(1, 20);
        pulse(0, 1);
        pulse(0, 4);
        pulse(0, 7);
        drain();

        // 5a: echo high through reset release -> nothing measured
        @(negedge clk);
        echo[0] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        echo[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("held_busy", 32'(busy[0]), 0);
        pulse(0, 12);
        drain();

        // 5b: reset mid-count aborts and clears result
        pulse(1, 24);
        drain();
        @(negedge clk);
        echo[1] = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_busy", 32'(busy[1]), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_period", 32'(period[1*W +: W]), 0);
        check("mid_busy_after", 32'(busy[1]), 0);
        repeat (10) @(negedge clk);
        echo[1] = 1'b0;
        repeat (10) @(negedge clk);
        pulse(1, 9);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
